// File: rtl/toa_pkg.sv
// Shared types and helpers for the TOA raw-code generator.
// Holds the word widths, the generator FSM state encoding and the
// alternating delay-line image builder.
package toa_pkg;

  localparam int RAW_W    = 63;
  localparam int COARSE_W = 3;
  localparam int FINE_W   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Delay-line image for a fine phase. Bits at or below the break follow
  // ~i[0] and bits above it follow i[0], so the single equal adjacent pair
  // sits at (fine, fine+1). An illegal fine yields the pure alternating word.
  function automatic logic [RAW_W-1:0] alt_image(input logic [FINE_W-1:0] fine,
                                                 input logic              legal);
    logic [RAW_W-1:0] img;
    img = '0;
    for (int i = 0; i < RAW_W; i++) begin
      if (!legal || i <= int'(fine)) img[i] = ((i % 2) == 0);
      else                           img[i] = ((i % 2) == 1);
    end
    return img;
  endfunction

endpackage

// File: rtl/toa_raw_image.sv
// Combinational fine phase -> 63-bit delay-line image plus legality flag.
module toa_raw_image
  import toa_pkg::*;
#(
  parameter int FINE_MAX = 61
) (
  input  logic [FINE_W-1:0] i_fine,
  output logic [RAW_W-1:0]  o_image,
  output logic              o_legal
);

  assign o_legal = (int'(i_fine) <= FINE_MAX);
  assign o_image = alt_image(i_fine, o_legal);

endmodule

// File: rtl/toa_rawcode_gen.sv
// TOA raw-code generator: turns a (coarse, fine) phase request into the raw
// TDC word (delay-line image + two coarse counters) and streams it out over
// valid/ready. Supports single words and automatic fine-phase sweeps.
// Optional feature macro: TOA_GEN_BUBBLE_EN adds the bubble_pos port and
// inverts one image bit per word (bubble injection).
//
// Timing: accept cycle (IDLE) -> BUILD cycle loads the output registers ->
// HOLD with out_valid high until the consumer takes the word.
module toa_rawcode_gen
  import toa_pkg::*;
#(
  parameter int FINE_MAX = 61,
  parameter int SPLIT    = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [COARSE_W-1:0] req_coarse,
  input  logic [FINE_W-1:0]   req_fine,
  input  logic                req_sweep,
  input  logic [7:0]          sweep_len,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RAW_W-1:0]    raw_code,
  output logic [COARSE_W-1:0] counter_a,
  output logic [COARSE_W-1:0] counter_b,
  output logic                err,
  output logic                busy
`ifdef TOA_GEN_BUBBLE_EN
  ,
  input  logic [5:0]          bubble_pos
`endif
);

  state_t              r_state, w_next;
  logic [COARSE_W-1:0] r_coarse;
  logic [FINE_W-1:0]   r_fine;
  logic                r_sweep;
  logic [7:0]          r_remain;
  logic [RAW_W-1:0]    r_raw;
  logic [COARSE_W-1:0] r_cnt_a, r_cnt_b;
  logic                r_err;
  logic                r_valid;
`ifdef TOA_GEN_BUBBLE_EN
  logic [5:0]          r_bubble;
`endif

  logic [RAW_W-1:0]    w_image;
  logic                w_legal;
  logic [RAW_W-1:0]    w_raw;
  logic [COARSE_W-1:0] w_cnt_b;
  logic                w_hs;
  logic                w_last;
  logic                w_fine_wrap;

  toa_raw_image #(.FINE_MAX(FINE_MAX)) u_image (
    .i_fine  (r_fine),
    .o_image (w_image),
    .o_legal (w_legal)
  );

  // Final image: clean word, optionally with one injected bubble
  always_comb begin
    w_raw = w_image;
`ifdef TOA_GEN_BUBBLE_EN
    if (r_bubble <= 6'd62) w_raw[r_bubble] = ~w_image[r_bubble];
`endif
  end

  // counterB lags counterA by one from the split point upward
  assign w_cnt_b = (int'(r_fine) < SPLIT) ? r_coarse : (r_coarse - 3'd1);

  // Handshake only counts while a word is actually presented
  assign w_hs        = r_valid && out_ready;
  // A single word, the final sweep word, or an illegal start ends the run
  assign w_last      = !r_sweep || (r_remain <= 8'd1) || r_err;
  assign w_fine_wrap = (int'(r_fine) == FINE_MAX);

  // Reset holds req_ready low even though the FSM already sits in IDLE
  assign req_ready = (r_state == IDLE) && rstn;
  assign busy      = (r_state != IDLE);
  assign out_valid = r_valid;
  assign raw_code  = r_raw;
  assign counter_a = r_cnt_a;
  assign counter_b = r_cnt_b;
  assign err       = r_err;

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = BUILD;
      BUILD:   w_next = HOLD;
      HOLD:    if (w_hs) w_next = w_last ? IDLE : BUILD;
      default: w_next = IDLE;
    endcase
  end

  // Request latch and sweep advance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_coarse <= '0;
      r_fine   <= '0;
      r_sweep  <= 1'b0;
      r_remain <= '0;
`ifdef TOA_GEN_BUBBLE_EN
      r_bubble <= 6'd63;
`endif
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_coarse <= req_coarse;
        r_fine   <= req_fine;
        r_sweep  <= req_sweep;
        r_remain <= (sweep_len == 8'd0) ? 8'd1 : sweep_len;
`ifdef TOA_GEN_BUBBLE_EN
        r_bubble <= bubble_pos;
`endif
      end else if (r_state == HOLD && w_hs && !w_last) begin
        r_remain <= r_remain - 8'd1;
        if (w_fine_wrap) begin
          r_fine   <= '0;
          r_coarse <= r_coarse + 3'd1;
        end else begin
          r_fine   <= r_fine + 7'd1;
        end
      end
    end
  end

  // Output word registers; they only change in BUILD so they stay stable in HOLD
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_raw   <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_err   <= 1'b0;
    end else if (r_state == BUILD) begin
      r_raw   <= w_raw;
      r_cnt_a <= r_coarse;
      r_cnt_b <= w_cnt_b;
      r_err   <= !w_legal;
    end
  end

  // out_valid: raised by BUILD, dropped by the handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                         r_valid <= 1'b0;
    else if (r_state == BUILD)         r_valid <= 1'b1;
    else if (r_state == HOLD && w_hs)  r_valid <= 1'b0;
  end

endmodule

// File: tb/tb_toa_rawcode_gen.sv
// Self-checking bench for toa_rawcode_gen: table of directed vectors,
// hand sequences for sweep / reset corners, then randomized requests
// against a behavioural word model.
module tb_toa_rawcode_gen;
  import toa_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_coarse = '0;
  logic [6:0]  req_fine = '0;
  logic        req_sweep = 1'b0;
  logic [7:0]  sweep_len = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [62:0] raw_code;
  logic [2:0]  counter_a, counter_b;
  logic        err, busy;
`ifdef TOA_GEN_BUBBLE_EN
  logic [5:0]  bubble_pos = 6'd63;
`endif

  toa_rawcode_gen dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_coarse(req_coarse), .req_fine(req_fine),
    .req_sweep(req_sweep), .sweep_len(sweep_len),
    .out_valid(out_valid), .out_ready(out_ready),
    .raw_code(raw_code), .counter_a(counter_a), .counter_b(counter_b),
    .err(err), .busy(busy)
`ifdef TOA_GEN_BUBBLE_EN
    , .bubble_pos(bubble_pos)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [62:0] raw;
    logic [2:0]  ca;
    logic [2:0]  cb;
    logic        err;
  } word_t;

  typedef struct {
    int          coarse;
    int          fine;
    logic        has_raw;
    logic [62:0] raw;
    logic [2:0]  ca;
    logic [2:0]  cb;
    logic        err;
  } vec_t;

  word_t got_first;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word model: start from the pure alternating pattern and flip every bit
  // above the break for a legal fine phase; bubble flips one more bit.
  function automatic word_t model(input int coarse, input int fine, input int bub);
    word_t w;
    logic [63:0] alt;
    logic [63:0] above;
    alt   = 64'h5555_5555_5555_5555;
    w.err = (fine > 61);
    above = w.err ? 64'd0 : ~((64'd2 << fine) - 64'd1);
    w.raw = 63'(alt ^ above);
    if (bub >= 0 && bub <= 62) w.raw[bub] = ~w.raw[bub];
    w.ca  = 3'(coarse);
    w.cb  = (fine >= 32) ? 3'((coarse + 7) % 8) : 3'(coarse);
    return w;
  endfunction

  function automatic int equal_pairs(input logic [62:0] r);
    int n = 0;
    for (int i = 0; i < 62; i++) if (r[i] == r[i+1]) n++;
    return n;
  endfunction

  task automatic check_word(input string tag, input word_t e);
    chk({tag, ".raw"}, {1'b0, raw_code}, {1'b0, e.raw});
    chk({tag, ".ca"}, {61'd0, counter_a}, {61'd0, e.ca});
    chk({tag, ".cb"}, {61'd0, counter_b}, {61'd0, e.cb});
    chk({tag, ".err"}, {63'd0, err}, {63'd0, e.err});
  endtask

  // One request (single or sweep) from presentation to the last handshake,
  // with up to maxstall random stall cycles per word.
  task automatic run_req(input int coarse, input int fine, input int sweep,
                         input int len, input int bub, input int maxstall);
    word_t exp_q[$];
    int n, c, f, t, stall;
    c = coarse; f = fine;
    n = (len == 0) ? 1 : len;
    if (sweep == 0 || fine > 61) n = 1;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model(c, f, bub));
      f++;
      if (f > 61) begin f = 0; c = (c + 1) % 8; end
    end
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_coarse = 3'(coarse);
    req_fine   = 7'(fine);
    req_sweep  = sweep[0];
    sweep_len  = 8'(len);
`ifdef TOA_GEN_BUBBLE_EN
    bubble_pos = 6'(bub);
`endif
    out_ready  = 1'($urandom % 2);
    @(negedge clk);
    req_valid = 1'b0;
    req_fine  = 7'($urandom);
    chk("build.valid", 64'(out_valid), 64'd0);
    chk("build.busy", 64'(busy), 64'd1);
    chk("build.req_ready", 64'(req_ready), 64'd0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("hold.valid", 64'(out_valid), 64'd1);
      check_word("word", exp_q[k]);
      if (k == 0) begin
        got_first.raw = raw_code; got_first.ca = counter_a;
        got_first.cb = counter_b; got_first.err = err;
      end
      stall = $urandom_range(0, maxstall);
      for (int s = 0; s < stall; s++) begin
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall.valid", 64'(out_valid), 64'd1);
        check_word("stall", exp_q[k]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'($urandom % 2);
      chk("post_hs.valid", 64'(out_valid), 64'd0);
    end
    chk("done.busy", 64'(busy), 64'd0);
    chk("done.req_ready", 64'(req_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    // Directed table
    tbl[0] = '{2, 0,   1'b1, 63'h2AAA_AAAA_AAAA_AAAB, 3'd2, 3'd2, 1'b0};
    tbl[1] = '{0, 40,  1'b0, 63'd0,                   3'd0, 3'd7, 1'b0};
    tbl[2] = '{4, 100, 1'b1, 63'h5555_5555_5555_5555, 3'd4, 3'd3, 1'b1};
    tbl[3] = '{0, 61,  1'b1, 63'h1555_5555_5555_5555, 3'd0, 3'd7, 1'b0};
    tbl[4] = '{5, 31,  1'b0, 63'd0,                   3'd5, 3'd5, 1'b0};
    tbl[5] = '{5, 32,  1'b0, 63'd0,                   3'd5, 3'd4, 1'b0};

    // Reset state
    #12;
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.raw", {1'b0, raw_code}, 64'd0);
    chk("rst.ca", 64'(counter_a), 64'd0);
    chk("rst.cb", 64'(counter_b), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("release.req_ready", 64'(req_ready), 64'd1);

    for (int v = 0; v < 6; v++) begin
      run_req(tbl[v].coarse, tbl[v].fine, 0, 1, 63, (v == 0) ? 0 : 2);
      if (tbl[v].has_raw) chk("tbl.raw", {1'b0, got_first.raw}, {1'b0, tbl[v].raw});
      chk("tbl.ca", 64'(got_first.ca), 64'(tbl[v].ca));
      chk("tbl.cb", 64'(got_first.cb), 64'(tbl[v].cb));
      chk("tbl.err", 64'(got_first.err), 64'(tbl[v].err));
      if (!tbl[v].err) begin
        chk("tbl.pairs", 64'(equal_pairs(got_first.raw)), 64'd1);
        chk("tbl.pair_at_break", 64'(got_first.raw[tbl[v].fine] == got_first.raw[tbl[v].fine + 1]), 64'd1);
      end
    end

    // Sweep across the fine wrap with random stalls
    run_req(7, 60, 1, 4, 63, 3);
    // Sweep with illegal start: one err word only
    run_req(3, 90, 1, 5, 63, 1);
    // sweep_len of zero behaves as one
    run_req(1, 5, 1, 0, 63, 1);

    // Reset in the middle of a sweep (third word on the output)
    @(negedge clk);
    req_valid = 1'b1; req_coarse = 3'd7; req_fine = 7'd60;
    req_sweep = 1'b1; sweep_len = 8'd4; out_ready = 1'b1;
`ifdef TOA_GEN_BUBBLE_EN
    bubble_pos = 6'd63;
`endif
    @(negedge clk); req_valid = 1'b0;   // BUILD word 1
    @(negedge clk);                      // word 1 valid, taken at next edge
    @(negedge clk);                      // BUILD word 2
    @(negedge clk);                      // word 2 valid
    @(negedge clk);                      // BUILD word 3
    out_ready = 1'b0;
    @(negedge clk);
    chk("mid.valid", 64'(out_valid), 64'd1);
    check_word("mid", model(0, 0, 63));
    #2 rstn = 1'b0;
    #1;
    chk("midrst.valid", 64'(out_valid), 64'd0);
    chk("midrst.raw", {1'b0, raw_code}, 64'd0);
    chk("midrst.ca", 64'(counter_a), 64'd0);
    chk("midrst.cb", 64'(counter_b), 64'd0);
    chk("midrst.err", 64'(err), 64'd0);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst.idle_valid", 64'(out_valid), 64'd0);
    run_req(6, 12, 0, 1, 63, 2);

`ifdef TOA_GEN_BUBBLE_EN
    run_req(2, 10, 0, 1, 30, 1);
    chk("bubble.diff", {1'b0, got_first.raw ^ model(2, 10, 63).raw}, 64'd1 << 30);
    chk("bubble.err", 64'(got_first.err), 64'd0);
`endif

    // Randomized requests
    for (int r = 0; r < 14; r++) begin
      int bub;
`ifdef TOA_GEN_BUBBLE_EN
      bub = int'($urandom % 64);
`else
      bub = 63;
`endif
      run_req(int'($urandom % 8), int'($urandom % 70), int'($urandom % 2),
              int'($urandom % 6), bub, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
